// File: rtl/line_mem_responder.sv
// line_mem_responder: memory-end responder for Muskbus 64-byte line transfers.
// Serves line reads (after READ_LATENCY idle cycles) and line write-backs
// as eight 64-bit beats against a line-granular backing store.
// Optional build macro: CRIT_WORD_FIRST_EN makes reads start at word addr[5:3]
// and wrap through the line. Without it, reads always start at word 0.
module line_mem_responder #(
    parameter int LINES        = 64,
    parameter int READ_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqcyc,
    output logic        reqack,
    input  logic [63:0] req,
    input  logic [12:0] reqtag,
    output logic        respcyc,
    input  logic        respack,
    output logic [63:0] resp,
    output logic [12:0] resptag
);
    localparam int IDX_W = $clog2(LINES);

    typedef enum logic [2:0] {IDLE, WDATA, WACK, RWAIT, RDATA} state_t;

    state_t         state_q, state_d;
    logic [63:6]    addr_q, addr_d;
    logic [12:0]    tag_q, tag_d;
    logic [2:0]     start_q, start_d;
    logic [2:0]     beat_q, beat_d;
    logic [3:0]     lat_q, lat_d;
    logic [447:0]   stage_q, stage_d;   // words 0-6; word 7 comes straight off req at commit
    logic           reqack_q, reqack_d;
    logic           respcyc_q, respcyc_d;
    logic [63:0]    resp_q, resp_d;
    logic [12:0]    resptag_q, resptag_d;

    logic [511:0]   mem [LINES];
    logic           mem_we;
    logic [IDX_W-1:0] idx_lat, idx_req;
    logic [2:0]     start_req, word_nxt;

    assign idx_lat = addr_q[6 +: IDX_W];
    assign idx_req = req[6 +: IDX_W];
`ifdef CRIT_WORD_FIRST_EN
    assign start_req = req[5:3];
`else
    assign start_req = 3'd0;
`endif
    assign word_nxt = start_q + beat_q + 3'd1;

    assign reqack  = reqack_q;
    assign respcyc = respcyc_q;
    assign resp    = resp_q;
    assign resptag = resptag_q;

    function automatic logic [63:0] rd_word(input logic [511:0] line, input logic [2:0] w);
        return line[{w, 6'b0} +: 64];
    endfunction

    // Next-state and next-output logic; outputs are registered so they hold
    // stable while the consumer stalls.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tag_d     = tag_q;
        start_d   = start_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        stage_d   = stage_q;
        reqack_d  = reqack_q;
        respcyc_d = respcyc_q;
        resp_d    = resp_q;
        resptag_d = resptag_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                reqack_d = 1'b1;
                if (reqcyc) begin
                    addr_d = req[63:6];
                    tag_d  = reqtag;
                    beat_d = 3'd0;
                    if (reqtag[12]) begin
                        state_d = WDATA;
                    end else begin
                        reqack_d = 1'b0;
                        start_d  = start_req;
                        if (READ_LATENCY == 0) begin
                            // No wait cycles: first beat is presented right away
                            state_d   = RDATA;
                            respcyc_d = 1'b1;
                            resp_d    = rd_word(mem[idx_req], start_req);
                            resptag_d = reqtag;
                        end else begin
                            state_d = RWAIT;
                            lat_d   = 4'(READ_LATENCY);
                        end
                    end
                end
            end
            WDATA: begin
                if (reqcyc) begin
                    if (beat_q == 3'd7) begin
                        // Commit the whole line before acknowledging so a
                        // following read sees the new data
                        mem_we    = 1'b1;
                        state_d   = WACK;
                        reqack_d  = 1'b0;
                        respcyc_d = 1'b1;
                        resp_d    = {addr_q, 6'b0};
                        resptag_d = tag_q;
                    end else begin
                        stage_d[{beat_q, 6'b0} +: 64] = req;
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            WACK: begin
                if (respack) begin
                    state_d   = IDLE;
                    reqack_d  = 1'b1;
                    respcyc_d = 1'b0;
                    resp_d    = '0;
                    resptag_d = '0;
                end
            end
            RWAIT: begin
                lat_d = lat_q - 4'd1;
                if (lat_q <= 4'd1) begin
                    state_d   = RDATA;
                    beat_d    = 3'd0;
                    respcyc_d = 1'b1;
                    resp_d    = rd_word(mem[idx_lat], start_q);
                    resptag_d = tag_q;
                end
            end
            RDATA: begin
                if (respack) begin
                    if (beat_q == 3'd7) begin
                        state_d   = IDLE;
                        reqack_d  = 1'b1;
                        respcyc_d = 1'b0;
                        resp_d    = '0;
                        resptag_d = '0;
                    end else begin
                        beat_d = beat_q + 3'd1;
                        resp_d = rd_word(mem[idx_lat], word_nxt);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and registered outputs; reset aborts any transfer in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            tag_q     <= '0;
            start_q   <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            stage_q   <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tag_q     <= tag_d;
            start_q   <= start_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            stage_q   <= stage_d;
            reqack_q  <= reqack_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
        end
    end

    // Backing store: whole-line commit, contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_lat] <= {req, stage_q};
    end
endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Memory-end responder for Muskbus line transfers. It answers the 64-byte line reads and line write-backs that a cache's bus reader and writer issue.
- It holds a line-granular backing store and serves each request as a sequence of 64-bit beats.
- It sits at the far end of the bus from the data cache. It is used as the bench memory model and as a synthesizable on-chip scratch memory.

Parameters:
- LINES, 64, number of 64-byte lines stored; power of two, at least 2.
- READ_LATENCY, 4, idle cycles between accepting a read address and raising the first read beat; range 0-15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- reqcyc  in  1  request beat valid
- reqack  out  1  request beat accepted; a beat transfers on reqcyc && reqack
- req  in  64  beat 0 carries the byte address; beats 1-8 carry write data
- reqtag  in  13  bit 12: 1 = line write, 0 = line read; bits 11:0 are an opaque id
- respcyc  out  1  response beat valid
- respack  in  1  response beat consumed; a beat transfers on respcyc && respack
- resp  out  64  response data
- resptag  out  13  echo of the reqtag captured with beat 0

Behaviour:
- Reset, asynchronous and active-high: FSM goes to IDLE; reqack, respcyc, resp and resptag all read 0; beat and latency counters clear.
  - Reset during any transfer aborts it.
  - Write data already latched but not committed is discarded.
  - Storage contents are not reset. The simulation model zero-initialises storage at time 0.
- Line index = addr[6+log2(LINES)-1:6]. Higher address bits are ignored, so the store aliases modulo LINES lines. addr[5:0] is ignored unless CRIT_WORD_FIRST_EN is defined.
- IDLE: reqack=1. When reqcyc is high:
  - Latch address and tag.
  - reqtag[12]=1 goes to WDATA, beat counter = 0.
  - reqtag[12]=0 goes to RWAIT, latency counter = READ_LATENCY.
- WDATA: reqack=1.
  - Each accepted beat k (0-7) goes to a staging line at word k. Staging word 0 = bits [63:0] = byte offset 0.
  - Cycles with reqcyc low are stalls; the counter holds.
  - After beat 7 the whole staged line is committed to storage in the same cycle, then the FSM goes to WACK.
  - Partial writes never reach storage.
- WACK: respcyc=1, resp = latched line address with bits [5:0] cleared, resptag = latched tag.
  - Held stable until respack, then the FSM goes to IDLE.
- RWAIT: reqack=0. The latency counter decrements each cycle; at 0 the FSM goes to RDATA, beat counter = 0.
  - With READ_LATENCY=0, the first read beat is valid the cycle after address acceptance.
- RDATA: reqack=0, respcyc=1, resp = word (start + beat) mod 8 of the line as stored, resptag = latched tag.
  - resp, resptag and respcyc stay stable while respack is low.
  - Each acknowledged beat advances the counter. Acknowledgement of beat 7 goes to IDLE, and respcyc drops in the next cycle.
- Only one transaction is outstanding at a time. reqack=0 in every state except IDLE and WDATA.
- A read issued immediately after a write to the same line returns the new data, because the commit precedes WACK.
- Throughput:
  - Read: 1 + READ_LATENCY + 8 cycles minimum.
  - Write: 9 beats + 1 ack cycle minimum.
- Back-to-back: the cycle after WACK or RDATA completes, IDLE accepts a new address.

Optional Feature:
- CRIT_WORD_FIRST_EN defined: for reads, start = addr[5:3]. Beats wrap through all 8 words, e.g. start 5 gives words 5,6,7,0,1,2,3,4.
- Not defined: start = 0 always and addr[5:3] is ignored.
- Writes always use start 0 in both builds.

Test Plan:
- Reset: assert reset asynchronously mid-RDATA with respack held low. Required: respcyc, reqack, resp and resptag read 0 immediately; after release, IDLE with reqack=1; storage unchanged.
- Write then read: write line 0x1C0 (tag 0x1005) with words 0x11..0x88. Required: WACK resp=0x1C0, resptag=0x1005. Then read 0x1C0 (tag 0x0007); required: first beat exactly 5 cycles after address acceptance, beats 0x11..0x88 in order, resptag=0x0007.
- Stalls: write with reqcyc dropped for 3 cycles between beats 3 and 4, then read with respack low for 2 cycles on beat 2. Required: correct data, and no beat lost or duplicated.
- Aliasing: with LINES=64, write address 0x1000 with pattern A, then read address 0x0000. Required: pattern A returned.
- READ_LATENCY=0 back-to-back: issue two reads in consecutive opportunities. Required: the second address is accepted the cycle after beat 7 is acknowledged.
- CRIT_WORD_FIRST_EN: read address 0x1E8 with words 0x11..0x88 stored. Required: 0x66,0x77,0x88,0x11,0x22,0x33,0x44,0x55. With the macro off, required: 0x11 first.
